// File: rtl/dft64_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dft64_frame_ctrl
// Brief    : Frame sequencer for dft64. It buffers 64-sample frames in a
//            ping-pong store, loads each frame into dft64 as eight beats,
//            waits for done (with a timeout) and holds the result handshake
//            until downstream takes it.
// Revision : 1.0 - initial release
// ============================================================================
module dft64_frame_ctrl #(
  parameter int SAMPLE_W    = 16,
  parameter int FRAME_N     = 64,
  parameter int BEAT_N      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                       clk,
  input  logic                       areset_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [SAMPLE_W-1:0]        s_data,
  output logic                       dft_sreset,
  output logic                       dft_calculate,
  output logic                       dft_rel,
  output logic [BEAT_N*SAMPLE_W-1:0] dft_samples,
  input  logic                       dft_done,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       timeout_err,
  output logic [15:0]                frame_cnt
);

  localparam int FILL_W = $clog2(FRAME_N);
  localparam int BEATS  = FRAME_N / BEAT_N;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int LANE_W = $clog2(BEAT_N);
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST    = 3'd1,
    LOAD   = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4
  } state_t;

  logic [SAMPLE_W-1:0]        mem [2][FRAME_N];
  logic                       wr_bank;
  logic                       cmp_bank;
  logic [1:0]                 full;
  logic [1:0]                 full_nxt;
  logic                       wr_bank_nxt;
  logic [FILL_W-1:0]          fill;
  state_t                     state;
  logic [BEAT_W-1:0]          beat;
  logic [BEAT_W-1:0]          beat_nxt;
  logic [WAIT_W-1:0]          wait_cnt;
  logic                       accept;
  logic                       frame_last;
  logic                       release_bank;
  logic [BEAT_N*SAMPLE_W-1:0] payload;

  assign accept     = s_valid && s_ready;
  assign frame_last = accept && (fill == FILL_W'(FRAME_N - 1));

  // The compute bank is freed either on a timeout or when the result is taken.
  assign release_bank = ((state == WAIT) && !dft_done && (wait_cnt == WAIT_W'(TIMEOUT_CYC)))
                     || ((state == RESULT) && res_ready);

  // Next bank occupancy; the write side moves to the other bank whenever its own is full and the other is free.
  always_comb begin
    full_nxt = full;
    if (release_bank) full_nxt[cmp_bank] = 1'b0;
    if (frame_last)   full_nxt[wr_bank]  = 1'b1;
    wr_bank_nxt = wr_bank;
    if (full_nxt[wr_bank] && !full_nxt[~wr_bank]) wr_bank_nxt = ~wr_bank;
  end

  // Beat index presented on the next cycle: beat 0 leaving RST, otherwise the following beat.
  assign beat_nxt = (state == LOAD) ? beat + 1'b1 : '0;

  generate
    for (genvar i = 0; i < BEAT_N; i++) begin : g_lane
      // Lowest-index sample of the beat lands in the most significant lane.
      assign payload[(BEAT_N-1-i)*SAMPLE_W +: SAMPLE_W] = mem[cmp_bank][{beat_nxt, LANE_W'(i)}];
    end
  endgenerate

  // Sample intake: bank write, fill pointer, bank occupancy and the registered ready.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int n = 0; n < FRAME_N; n++) mem[b][n] <= '0;
      end
      full    <= 2'b00;
      wr_bank <= 1'b0;
      fill    <= '0;
      s_ready <= 1'b0;
    end else begin
      full    <= full_nxt;
      wr_bank <= wr_bank_nxt;
      s_ready <= !full_nxt[wr_bank_nxt];
      if (accept) begin
        mem[wr_bank][fill] <= s_data;
        fill <= frame_last ? '0 : fill + 1'b1;
      end
    end
  end

  // Frame sequencer with registered dft64 controls and result handshake.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state         <= IDLE;
      cmp_bank      <= 1'b0;
      beat          <= '0;
      wait_cnt      <= '0;
      dft_sreset    <= 1'b0;
      dft_calculate <= 1'b0;
      dft_rel       <= 1'b0;
      dft_samples   <= '0;
      res_valid     <= 1'b0;
      timeout_err   <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (full[~wr_bank]) begin
            cmp_bank   <= ~wr_bank;
            dft_sreset <= 1'b1;
            state      <= RST;
          end
        end
        RST: begin
          dft_sreset    <= 1'b0;
          dft_calculate <= 1'b1;
          dft_rel       <= 1'b1;
          dft_samples   <= payload;
          beat          <= '0;
          state         <= LOAD;
        end
        LOAD: begin
          if (beat == BEAT_W'(BEATS - 1)) begin
            dft_rel     <= 1'b0;
            dft_samples <= '0;
            wait_cnt    <= WAIT_W'(1);
            state       <= WAIT;
          end else begin
            beat        <= beat_nxt;
            dft_samples <= payload;
          end
        end
        WAIT: begin
          if (dft_done) begin
            res_valid <= 1'b1;
            state     <= RESULT;
          end else if (wait_cnt == WAIT_W'(TIMEOUT_CYC)) begin
            timeout_err   <= 1'b1;
            frame_cnt     <= frame_cnt + 16'd1;
            dft_calculate <= 1'b0;
            state         <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid     <= 1'b0;
            frame_cnt     <= frame_cnt + 16'd1;
            dft_calculate <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dft64_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dft64_frame_ctrl
// Brief    : Scoreboard bench for dft64_frame_ctrl with a dft64 done model
//            and a downstream result consumer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dft64_frame_ctrl;

  logic         clk = 1'b0;
  logic         areset_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [15:0]  s_data = '0;
  logic         dft_sreset;
  logic         dft_calculate;
  logic         dft_rel;
  logic [127:0] dft_samples;
  logic         dft_done = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic         timeout_err;
  logic [15:0]  frame_cnt;

  dft64_frame_ctrl dut (
    .clk(clk), .areset_n(areset_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .dft_sreset(dft_sreset), .dft_calculate(dft_calculate),
    .dft_rel(dft_rel), .dft_samples(dft_samples), .dft_done(dft_done),
    .res_valid(res_valid), .res_ready(res_ready), .timeout_err(timeout_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [127:0] bq[$];
  logic [15:0]  fbuf[64];
  int mcnt = 0;
  int exp_frames = 0;
  int serial = 0;

  int done_at = 3;
  bit rand_done = 1'b0;
  int armed = 0;
  int wc = 0;

  int res_mode = 0;
  int hold = 0;
  int rv = 0;
  int rv_total = 0;
  int hs_cnt = 0;

  int rel_seen = 0;
  int bidx = 0;
  int sreset_total = 0;
  logic [127:0] first_beat = '0;

  // Reference frame store: a full frame becomes eight expected beats.
  task automatic model_push(input logic [15:0] d);
    logic [127:0] b;
    fbuf[mcnt] = d;
    mcnt++;
    if (mcnt == 64) begin
      for (int k = 0; k < 8; k++) begin
        b = '0;
        for (int i = 0; i < 8; i++) b[(127-16*i) -: 16] = fbuf[8*k+i];
        bq.push_back(b);
      end
      exp_frames++;
      mcnt = 0;
    end
  endtask

  // Beat monitor: every rel pulse is popped from the scoreboard and compared.
  task automatic mon_beats();
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if (areset_n && dft_sreset) begin
        sreset_total++;
        bidx = 0;
      end
      if (areset_n && dft_rel) begin
        total++;
        if (bq.size() == 0) begin
          $display("FAIL beat: unexpected rel pulse payload=%h required=none", dft_samples);
        end else begin
          e = bq.pop_front();
          if (dft_samples !== e || dft_calculate !== 1'b1)
            $display("FAIL beat: payload=%h calc=%b required payload=%h calc=1", dft_samples, dft_calculate, e);
          else
            passed++;
        end
        if (bidx == 0) first_beat = dft_samples;
        bidx++;
        rel_seen++;
      end
    end
  endtask

  // dft64 model: raises done on WAIT cycle done_at (0 = never); random noise outside WAIT when enabled.
  task automatic drive_done();
    forever begin
      @(negedge clk);
      if (!areset_n) begin
        armed = 0; wc = 0; dft_done = 1'b0;
      end else if (dft_rel) begin
        armed = 1; wc = 0; dft_done = 1'b0;
        if (rand_done) done_at = $urandom_range(1, 12);
      end else if (armed != 0 && dft_calculate && !res_valid) begin
        wc++;
        dft_done = (done_at != 0 && wc >= done_at);
      end else begin
        armed = 0;
        dft_done = rand_done ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  endtask

  // Downstream consumer: always ready, ready after a hold, or random.
  task automatic drive_res();
    forever begin
      @(negedge clk);
      if (!areset_n) begin
        rv = 0; res_ready = 1'b0;
      end else begin
        if (res_valid) begin rv++; rv_total++; end else rv = 0;
        case (res_mode)
          0:       res_ready = 1'b1;
          1:       res_ready = res_valid && (rv > hold);
          default: res_ready = 1'($urandom_range(0, 1));
        endcase
        if (res_valid && res_ready) hs_cnt++;
      end
    end
  endtask

  // Sample source: kind 0 = 1 kHz sine at 48 kHz, 1 = random, 2 = running counter.
  task automatic feed(input int n, input int gap_pct, input int kind);
    int acc = 0;
    int cyc = 0;
    logic [15:0] d;
    bit v;
    while (acc < n) begin
      @(negedge clk);
      cyc++;
      if (cyc > n * 8 + 500) begin
        total++;
        $display("FAIL feed: accepted=%0d required=%0d within budget", acc, n);
        break;
      end
      case (kind)
        0:       d = 16'(int'(256.0 * $sin(2.0 * 3.14159265358979 * 1000.0 * real'(acc) / 48000.0)));
        1:       d = 16'($urandom);
        default: d = 16'(serial);
      endcase
      v = ($urandom_range(0, 99) >= gap_pct);
      s_valid = v;
      s_data  = d;
      if (v && s_ready) begin
        model_push(d);
        acc++;
        if (kind == 2) serial++;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Waits for all expected beats and compute activity to finish, then checks frame_cnt.
  task automatic wait_idle(input string name);
    int quiet = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk); #1;
      if (bq.size() == 0 && !dft_calculate && !dft_sreset && !res_valid) quiet++;
      else quiet = 0;
      if (quiet >= 4) break;
    end
    total++;
    if (quiet < 4) $display("FAIL %s_idle: pending beats=%0d required 0 within budget", name, bq.size());
    else passed++;
    total++;
    if (frame_cnt !== 16'(exp_frames)) $display("FAIL %s_frame_cnt: got %0d required %0d", name, frame_cnt, exp_frames);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({s_ready, dft_sreset, dft_calculate, dft_rel, res_valid, timeout_err} !== 6'b0 ||
        dft_samples !== '0 || frame_cnt !== 16'd0)
      $display("FAIL reset_outputs: ready=%b calc=%b rel=%b rv=%b err=%b cnt=%0d required all 0",
               s_ready, dft_calculate, dft_rel, res_valid, timeout_err, frame_cnt);
    else passed++;
    areset_n = 1'b1;
    @(negedge clk); #1;
    total++;
    if (s_ready !== 1'b1) $display("FAIL reset_ready_after: got %b required 1", s_ready);
    else passed++;
  endtask

  task automatic test_basic();
    int s0 = sreset_total;
    int r0 = rv_total;
    int h0 = hs_cnt;
    res_mode = 0; done_at = 3; rand_done = 1'b0;
    feed(64, 0, 0);
    total++;
    if (dft_sreset !== 1'b0) $display("FAIL basic_sreset_early: got %b required 0", dft_sreset);
    else passed++;
    @(negedge clk);
    total++;
    if (dft_sreset !== 1'b1 || dft_calculate !== 1'b0)
      $display("FAIL basic_sreset_pulse: sreset=%b calc=%b required 1/0", dft_sreset, dft_calculate);
    else passed++;
    @(negedge clk);
    total++;
    if (dft_rel !== 1'b1 || dft_sreset !== 1'b0)
      $display("FAIL basic_first_beat: rel=%b sreset=%b required 1/0", dft_rel, dft_sreset);
    else passed++;
    wait_idle("basic");
    total++;
    if (first_beat[127:112] !== 16'd0 || first_beat[111:96] !== 16'd33)
      $display("FAIL basic_beat0: s0=%0d s1=%0d required 0/33", first_beat[127:112], first_beat[111:96]);
    else passed++;
    total++;
    if (sreset_total - s0 != 1) $display("FAIL basic_sreset_len: got %0d cycles required 1", sreset_total - s0);
    else passed++;
    total++;
    if (rv_total - r0 != 1 || hs_cnt - h0 != 1)
      $display("FAIL basic_res_valid: cycles=%0d handshakes=%0d required 1/1", rv_total - r0, hs_cnt - h0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int h0 = hs_cnt;
    res_mode = 1; hold = 20; done_at = 3;
    feed(192, 0, 2);
    wait_idle("b2b");
    total++;
    if (hs_cnt - h0 != 3) $display("FAIL b2b_results: got %0d required 3", hs_cnt - h0);
    else passed++;
  endtask

  task automatic test_backpressure();
    res_mode = 1; hold = 100; done_at = 3;
    feed(128, 0, 2);
    total++;
    if (s_ready !== 1'b0) $display("FAIL bp_ready_drop: got %b required 0", s_ready);
    else passed++;
    feed(64, 0, 2);
    wait_idle("bp");
  endtask

  task automatic test_done_boundary();
    int h0 = hs_cnt;
    res_mode = 0; done_at = 16;
    feed(64, 0, 1);
    wait_idle("boundary");
    total++;
    if (timeout_err !== 1'b0 || hs_cnt - h0 != 1)
      $display("FAIL boundary_done: err=%b results=%0d required 0/1", timeout_err, hs_cnt - h0);
    else passed++;
  endtask

  task automatic test_timeout();
    int h0 = hs_cnt;
    bit found = 1'b0;
    res_mode = 0; done_at = 0;
    feed(64, 0, 1);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (armed != 0 && wc == 16) begin found = 1'b1; break; end
    end
    total++;
    if (!found || timeout_err !== 1'b0)
      $display("FAIL timeout_wait16: reached=%b err=%b required 1/0", found, timeout_err);
    else passed++;
    @(negedge clk); #1;
    total++;
    if (timeout_err !== 1'b1 || res_valid !== 1'b0 || dft_calculate !== 1'b0)
      $display("FAIL timeout_flag: err=%b rv=%b calc=%b required 1/0/0", timeout_err, res_valid, dft_calculate);
    else passed++;
    done_at = 3;
    feed(64, 0, 1);
    wait_idle("timeout");
    total++;
    if (hs_cnt - h0 != 1 || timeout_err !== 1'b1)
      $display("FAIL timeout_next: results=%0d err=%b required 1/1", hs_cnt - h0, timeout_err);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int r0 = rel_seen;
    bit found = 1'b0;
    res_mode = 0; done_at = 3;
    feed(67, 0, 2);
    for (int c = 0; c < 100; c++) begin
      if (rel_seen == r0 + 5) begin found = 1'b1; break; end
      @(negedge clk); #1;
    end
    total++;
    if (!found) $display("FAIL rstmid_beat4: beats=%0d required %0d", rel_seen - r0, 5);
    else passed++;
    areset_n = 1'b0;
    #1;
    total++;
    if ({s_ready, dft_sreset, dft_calculate, dft_rel, res_valid, timeout_err} !== 6'b0 ||
        dft_samples !== '0 || frame_cnt !== 16'd0)
      $display("FAIL rstmid_outputs: ready=%b calc=%b rel=%b err=%b cnt=%0d required all 0",
               s_ready, dft_calculate, dft_rel, timeout_err, frame_cnt);
    else passed++;
    bq.delete();
    mcnt = 0;
    exp_frames = 0;
    repeat (2) @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk); #1;
    total++;
    if (s_ready !== 1'b1) $display("FAIL rstmid_ready: got %b required 1", s_ready);
    else passed++;
    repeat (30) @(negedge clk);
    #1;
    total++;
    if (rel_seen != r0 + 5) $display("FAIL rstmid_no_rel: beats=%0d required %0d", rel_seen - r0, 5);
    else passed++;
    feed(64, 0, 2);
    wait_idle("rstmid");
  endtask

  task automatic test_random();
    res_mode = 2; rand_done = 1'b1;
    feed(50 * 64, 30, 1);
    wait_idle("random");
    rand_done = 1'b0;
    total++;
    if (timeout_err !== 1'b0) $display("FAIL random_err: got %b required 0", timeout_err);
    else passed++;
  endtask

  initial begin
    fork
      mon_beats();
      drive_done();
      drive_res();
    join_none
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_done_boundary();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
